// File: rtl/arbitro_rr_n.sv
// Round-robin drain of NUM_CH source FIFOs into one sink; push/ch_out lag pop by 1 cycle, pop halts on almost_full.
// Optional ARB_WEIGHTED_EN adds a per-channel weight port replacing BURST_MAX as the burst limit.
module arbitro_rr_n #(
    parameter int NUM_CH    = 4,
    parameter int DATA_W    = 6,
    parameter int BURST_MAX = 8,
    parameter int CNT_W     = 4,
    parameter int CH_W      = 2
) (
    input  logic                     clk,
    input  logic                     reset_L,
    input  logic [NUM_CH-1:0]        fifo_empty,
    input  logic [NUM_CH*DATA_W-1:0] fifo_data,
    input  logic                     almost_full,
`ifdef ARB_WEIGHTED_EN
    input  logic [NUM_CH*CNT_W-1:0]  weight,
`endif
    output logic [NUM_CH-1:0]        pop,
    output logic                     push,
    output logic [DATA_W-1:0]        data_out,
    output logic [CH_W-1:0]          ch_out,
    output logic                     busy
);

    localparam logic [0:0]       IDLE   = 1'b0;
    localparam logic [0:0]       SERVE  = 1'b1;
    localparam logic [CH_W:0]    NCH    = (CH_W+1)'(NUM_CH);
    localparam logic [CH_W-1:0]  LAST   = CH_W'(NUM_CH - 1);
    localparam logic [CH_W-1:0]  CH_ONE = CH_W'(1);
    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

    logic [0:0]        state_q, state_d;
    logic [CH_W-1:0]   ptr_q, ptr_d;
    logic [CH_W-1:0]   cur_q, cur_d;
    logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic              push_q, push_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DATA_W-1:0] data_q, data_d;

    logic              found;
    logic [CH_W-1:0]   scan_idx;
    logic [CH_W:0]     sum;
    logic              cur_empty;
    logic              grant;
    logic [CH_W-1:0]   nxt_ptr;
    logic [CNT_W-1:0]  cnt_inc;
    logic [CNT_W-1:0]  lim;
    logic [DATA_W-1:0] data_sel;

`ifdef ARB_WEIGHTED_EN
    logic [CNT_W-1:0]  limit_q, limit_d;
    logic [CNT_W-1:0]  w_sel;

    always_comb begin
        w_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (scan_idx == CH_W'(i)) w_sel = weight[i*CNT_W +: CNT_W];
        end
    end
    assign lim = limit_q;
`else
    assign lim = CNT_W'(BURST_MAX);
`endif

    // Walk offsets high-to-low so the nearest non-empty channel after ptr wins.
    always_comb begin
        found    = 1'b0;
        scan_idx = '0;
        sum      = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            sum = {1'b0, ptr_q} + (CH_W+1)'(k);
            if (sum >= NCH) sum = sum - NCH;
            if (!fifo_empty[sum[CH_W-1:0]]) begin
                found    = 1'b1;
                scan_idx = sum[CH_W-1:0];
            end
        end
    end

    always_comb begin
        data_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_q == CH_W'(i)) data_sel = fifo_data[i*DATA_W +: DATA_W];
        end
    end

    assign cur_empty = fifo_empty[cur_q];
    assign grant     = (state_q == SERVE) && !cur_empty && !almost_full && (burst_cnt_q < lim);
    assign nxt_ptr   = (cur_q == LAST) ? '0 : cur_q + CH_ONE;
    assign cnt_inc   = burst_cnt_q + ONE;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pop[i] = grant && (cur_q == CH_W'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cur_d       = cur_q;
        burst_cnt_d = burst_cnt_q;
`ifdef ARB_WEIGHTED_EN
        limit_d     = limit_q;
`endif
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = SERVE;
                    cur_d       = scan_idx;
                    burst_cnt_d = '0;
`ifdef ARB_WEIGHTED_EN
                    limit_d     = (w_sel == '0) ? ONE : w_sel;
`endif
                end
            end
            default: begin
                // almost_full freezes the grant entirely, including the empty exit.
                if (!almost_full) begin
                    if (grant) begin
                        burst_cnt_d = cnt_inc;
                        if (cnt_inc == lim) begin
                            state_d = IDLE;
                            ptr_d   = nxt_ptr;
                        end
                    end else begin
                        state_d = IDLE;
                        ptr_d   = nxt_ptr;
                    end
                end
            end
        endcase
    end

    assign push_d = grant;
    assign ch_d   = grant ? cur_q : ch_q;
    assign data_d = push_q ? data_sel : data_q;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            cur_q       <= '0;
            burst_cnt_q <= '0;
            push_q      <= 1'b0;
            ch_q        <= '0;
            data_q      <= '0;
`ifdef ARB_WEIGHTED_EN
            limit_q     <= ONE;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cur_q       <= cur_d;
            burst_cnt_q <= burst_cnt_d;
            push_q      <= push_d;
            ch_q        <= ch_d;
            data_q      <= data_d;
`ifdef ARB_WEIGHTED_EN
            limit_q     <= limit_d;
`endif
        end
    end

    // Read data arrives the cycle after pop, so it is steered through while push is high.
    assign push     = push_q;
    assign data_out = data_d;
    assign ch_out   = ch_q;
    assign busy     = (state_q == SERVE);

endmodule

// File: tb/tb_arbitro_rr_n.sv
// Bench for arbitro_rr_n: queue-based source FIFOs and a transaction-level round-robin model
// predicting the pushed word stream and the per-cycle pop pattern.
module tb_arbitro_rr_n;

    localparam int NUM_CH    = 4;
    localparam int DATA_W    = 6;
    localparam int BURST_MAX = 8;
    localparam int CNT_W     = 4;
    localparam int CH_W      = 2;

    logic                     clk = 1'b0;
    logic                     reset_L;
    logic [NUM_CH-1:0]        fifo_empty;
    logic [NUM_CH*DATA_W-1:0] fifo_data;
    logic                     almost_full;
    logic [NUM_CH*CNT_W-1:0]  weight;
    logic [NUM_CH-1:0]        pop;
    logic                     push;
    logic [DATA_W-1:0]        data_out;
    logic [CH_W-1:0]          ch_out;
    logic                     busy;

    int n_chk = 0;
    int n_err = 0;

    logic [DATA_W-1:0]        fq[NUM_CH][$];
    logic [CH_W+DATA_W-1:0]   exp_q[$];
    int                       trace_q[$];
    int                       mptr = 0;
    int                       mw[NUM_CH];
    logic [DATA_W-1:0]        last_dat = '0;
    logic [DATA_W-1:0]        seq = 6'd1;
    bit                       w_chg_pending = 0;

    always #5 clk = ~clk;

    arbitro_rr_n #(
        .NUM_CH(NUM_CH), .DATA_W(DATA_W), .BURST_MAX(BURST_MAX), .CNT_W(CNT_W), .CH_W(CH_W)
    ) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .almost_full(almost_full),
`ifdef ARB_WEIGHTED_EN
        .weight     (weight),
`endif
        .pop        (pop),
        .push       (push),
        .data_out   (data_out),
        .ch_out     (ch_out),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
        end
    endtask

    task automatic upd_empty();
        for (int i = 0; i < NUM_CH; i++) fifo_empty[i] = (fq[i].size() == 0);
    endtask

    task automatic fill(input int ch, input int n);
        for (int j = 0; j < n; j++) begin
            fq[ch].push_back(seq);
            seq = seq + 6'd1;
        end
    endtask

    // Grant-level model: each grant is one bubble, then min(count, limit) pops,
    // plus one dead SERVE cycle when the burst ends because the source ran dry.
    function automatic void build_exp(input int chg1);
        int pos[NUM_CH];
        int rem[NUM_CH];
        int c, n, lim, left;
        bit seen = 0;
        trace_q.delete();
        for (int i = 0; i < NUM_CH; i++) begin
            pos[i] = 0;
            rem[i] = fq[i].size();
        end
        forever begin
            left = 0;
            for (int i = 0; i < NUM_CH; i++) left += rem[i];
            if (left == 0) break;
            c = -1;
            for (int k = 0; k < NUM_CH; k++) begin
                if (c < 0 && rem[(mptr + k) % NUM_CH] > 0) c = (mptr + k) % NUM_CH;
            end
            lim = (mw[c] == 0) ? 1 : mw[c];
            n   = (rem[c] < lim) ? rem[c] : lim;
            trace_q.push_back(0);
            for (int j = 0; j < n; j++) begin
                exp_q.push_back({2'(c), fq[c][pos[c] + j]});
                trace_q.push_back(1 << c);
            end
            if (n < lim) trace_q.push_back(0);
            pos[c] += n;
            rem[c] -= n;
            mptr = (c + 1) % NUM_CH;
            if (c == 1 && chg1 > 0 && !seen) begin
                mw[1] = chg1;
                seen  = 1;
            end
        end
    endfunction

    task automatic cycle(input logic af, input bit use_trace, output logic [NUM_CH-1:0] p);
        int pch;
        logic [CH_W+DATA_W-1:0] e;
        almost_full = af;
        #1;
        p = pop;
        chk("pop_onehot", 32'($onehot0(p)), 32'd1);
        for (int i = 0; i < NUM_CH; i++) if (p[i]) chk("pop_nonempty", 32'(fifo_empty[i]), 32'd0);
        if (af) chk("pop_hold_af", 32'(p), 32'd0);
        if (use_trace) chk("pop_trace", 32'(p), (trace_q.size() > 0) ? 32'(trace_q.pop_front()) : 32'd0);
        @(posedge clk);
        @(negedge clk);
        pch = -1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (p[i] && fq[i].size() > 0) begin
                pch = i;
                fifo_data[i*DATA_W +: DATA_W] = fq[i].pop_front();
            end
        end
        upd_empty();
`ifdef ARB_WEIGHTED_EN
        if (w_chg_pending && p[1]) begin
            weight[1*CNT_W +: CNT_W] = 4'd5;
            w_chg_pending = 0;
        end
`endif
        #1;
        chk("push", 32'(push), 32'(p != 0));
        if (p != 0) begin
            chk("ch_out", 32'(ch_out), 32'(pch));
            chk("stream_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("exp_ch", 32'(ch_out), 32'(e[CH_W+DATA_W-1:DATA_W]));
                chk("data_out", 32'(data_out), 32'(e[DATA_W-1:0]));
                last_dat = e[DATA_W-1:0];
            end
        end else begin
            chk("data_hold", 32'(data_out), 32'(last_dat));
        end
    endtask

    function automatic bit all_done();
        bit d = (exp_q.size() == 0);
        for (int i = 0; i < NUM_CH; i++) if (fq[i].size() != 0) d = 0;
        return d;
    endfunction

    task automatic run(input int maxc, input bit afrand, input bit use_trace, input string tag);
        logic [NUM_CH-1:0] p;
        int c = 0;
        while (!all_done() && c < maxc) begin
            cycle(afrand ? ($urandom_range(0, 3) == 0) : 1'b0, use_trace, p);
            c++;
        end
        chk({tag, "_drained"}, 32'(all_done()), 32'd1);
        for (int k = 0; k < 3; k++) cycle(1'b0, use_trace, p);
        chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [NUM_CH-1:0] p;
        bit seen;
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_CH-1:0] p;
        bit seen;
        reset_L     = 1'b0;
        almost_full = 1'b0;
        fifo_data   = '0;
        weight      = {NUM_CH{4'd8}};
        for (int i = 0; i < NUM_CH; i++) mw[i] = BURST_MAX;
        upd_empty();
        #12;
        chk("rst_pop", 32'(pop), 32'd0);
        chk("rst_push", 32'(push), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_ch", 32'(ch_out), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset_L = 1'b1;

        for (int k = 0; k < 20; k++) begin
            cycle(1'b0, 1'b0, p);
            chk("idle_busy", 32'(busy), 32'd0);
        end

        // Single channel: three known words on ch2.
        fq[2].push_back(6'h11);
        fq[2].push_back(6'h12);
        fq[2].push_back(6'h13);
        upd_empty();
        build_exp(-1);
        run(40, 1'b0, 1'b1, "single");

        // ptr now 3: ch3 must win over ch0.
        fill(0, 1);
        fill(3, 1);
        upd_empty();
        build_exp(-1);
        chk("ptr3_order", 32'(exp_q[0][CH_W+DATA_W-1:DATA_W]), 32'd3);
        run(40, 1'b0, 1'b1, "ptr3");

        // Burst limit: 8 ch0, 2 ch1, 4 ch0.
        fill(0, 12);
        fill(1, 2);
        upd_empty();
        build_exp(-1);
        run(80, 1'b0, 1'b1, "rr");

        // Backpressure in the middle of a ch3 burst.
        fill(3, 6);
        upd_empty();
        build_exp(-1);
        for (int k = 0; k < 20; k++) begin
            cycle((k >= 3 && k < 8), 1'b0, p);
            if (k >= 3 && k < 8) chk("bp_busy", 32'(busy), 32'd1);
            if (k == 8) chk("bp_resume", 32'(p), 32'd8);
        end
        chk("bp_drained", 32'(all_done()), 32'd1);
        chk("bp_idle", 32'(busy), 32'd0);

        // Reset the cycle after the first ch1 pop.
        fill(1, 4);
        upd_empty();
        build_exp(-1);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            almost_full = 1'b0;
            #1;
            if (pop[1]) seen = 1;
            else cycle(1'b0, 1'b0, p);
        end
        chk("rst_pop1_seen", 32'(seen), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (fq[1].size() > 0) fifo_data[1*DATA_W +: DATA_W] = fq[1].pop_front();
        upd_empty();
        reset_L = 1'b0;
        #1;
        chk("midrst_push", 32'(push), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pop", 32'(pop), 32'd0);
        exp_q.delete();
        last_dat = '0;
        mptr = 0;
        fill(0, 2);
        upd_empty();
        @(negedge clk);
        reset_L = 1'b1;
        build_exp(-1);
        chk("midrst_first_ch", 32'(exp_q[0][CH_W+DATA_W-1:DATA_W]), 32'd0);
        run(40, 1'b0, 1'b1, "midrst");

`ifdef ARB_WEIGHTED_EN
        weight = {4'd2, 4'd0, 4'd3, 4'd1};
        mw[0] = 1; mw[1] = 3; mw[2] = 0; mw[3] = 2;
        for (int i = 0; i < NUM_CH; i++) fill(i, 10);
        upd_empty();
        build_exp(5);
        w_chg_pending = 1;
        run(200, 1'b0, 1'b1, "weighted");
`endif

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NUM_CH; i++) fill(i, $urandom_range(0, 10));
            upd_empty();
            build_exp(-1);
            run(400, 1'b1, 1'b0, "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/arbitro_rr_n.md
Name: arbitro_rr_n

Overview:
- Parametrised successor to the 4-FIFO pop arbiter.
- Drains NUM_CH source FIFOs into one downstream FIFO in round-robin order.
- Limits each grant to a burst length and stalls on downstream almost_full.
- Provides registered push and data to the downstream FIFO, plus the source channel ID.

Parameters:
- NUM_CH, 4, number of source FIFOs (2..16).
- DATA_W, 6, word width per FIFO.
- BURST_MAX, 8, maximum words popped per grant before rotating (1..2^CNT_W-1).
- CNT_W, 4, width of the burst counter and the weight fields.
- CH_W, 2, channel index width; must equal ceil(log2(NUM_CH)).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_L  in  1  asynchronous active-low reset.
- fifo_empty  in  NUM_CH  per-source empty flag, updated on the same edge as the pop.
- fifo_data  in  NUM_CH*DATA_W  per-source read data; channel i at [i*DATA_W +: DATA_W]; valid the cycle after pop[i].
- almost_full  in  1  downstream almost-full flag.
- pop  out  NUM_CH  one-hot pop to the sources; combinational from registered state and current inputs.
- push  out  1  registered downstream write strobe.
- data_out  out  DATA_W  downstream write data, qualified by push.
- ch_out  out  CH_W  source channel of data_out.
- busy  out  1  high while in SERVE.

Behaviour:
- Reset (async, reset_L=0): state=IDLE, ptr=0, cur=0, burst_cnt=0, push=0, pop=0, data_out=0, ch_out=0, busy=0. Assertion mid-burst discards the in-flight word; no push follows.
- State machine, states IDLE and SERVE.
- IDLE: scan from ptr upward, wrapping modulo NUM_CH, for the first i with fifo_empty[i]=0.
  - If found: cur<=i, burst_cnt<=0, go to SERVE next cycle.
  - If none found: stay in IDLE.
  - No pop is issued in IDLE, so every grant costs exactly one bubble cycle.
- SERVE: pop[cur]=1 when fifo_empty[cur]=0 and almost_full=0 and burst_cnt<LIMIT. Each pop increments burst_cnt.
- Leaving SERVE: if fifo_empty[cur]=1, or burst_cnt reaches LIMIT after a pop, then ptr<=(cur+1) mod NUM_CH and state<=IDLE.
- Empty and limit coinciding: a single transition; ptr advances once.
- almost_full=1 in SERVE: pop=0 and the state holds. No rotation and no counter change; the burst resumes when almost_full drops.
- Pop/push timing: push and ch_out follow pop by exactly 1 cycle.
  - Cycle N pop[i]=1 -> cycle N+1 push=1, ch_out=i, data_out=fifo_data slice i (data_out is registered on the N+1->N+2 edge and held until the next push).
  - Worst-case downstream overshoot after almost_full rises is 1 word. The downstream almost_full threshold must reserve at least 1 entry.
- pop is always one-hot or zero. Popping an empty FIFO is illegal and must never occur.
- ptr wrap: NUM_CH-1 -> 0. burst_cnt never exceeds LIMIT.
- LIMIT = BURST_MAX unless the optional feature is enabled.
- Throughput: one word per cycle within a burst.

Optional Feature:
- Macro: ARB_WEIGHTED_EN.
- Defined:
  - Adds input port weight [NUM_CH*CNT_W] (channel i at [i*CNT_W +: CNT_W]).
  - LIMIT for cur equals weight[cur], sampled at the IDLE->SERVE transition; a value of 0 is treated as 1.
  - Weight changes mid-burst take effect on the next grant.
- Undefined: no weight port; LIMIT=BURST_MAX for all channels.

Test Plan:
- Reset/idle: reset_L=0 with all fifo_empty=1 -> pop=0, push=0, data_out=0. After release with all sources empty, busy stays 0 for 20 cycles.
- Single channel: FIFO2 holds 3 words (0x11, 0x12, 0x13), others empty. Expect:
  - 1 bubble cycle, then pop[2] for 3 consecutive cycles.
  - push on the next 3 cycles with data 0x11, 0x12, 0x13 and ch_out=2.
  - Return to IDLE with ptr=3.
- Round-robin and burst limit: BURST_MAX=8, FIFO0 holds 12 words, FIFO1 holds 2 -> order is 8 from ch0, 2 from ch1, 4 from ch0. Each grant is preceded by exactly 1 bubble.
- Backpressure: raise almost_full for 5 cycles mid-burst on ch3 -> pop=0 during the hold, cur stays 3, burst_cnt unchanged. At most 1 push after the assertion cycle; the burst completes with no words lost or duplicated.
- Reset mid-operation: drop reset_L the cycle after pop[1] -> push=0 immediately, with no push of the in-flight word. After release the scan restarts at ch0.
- ARB_WEIGHTED_EN: weights {1, 3, 0, 2}, all FIFOs deep -> bursts of 1, 3, 1, 2 repeating. Changing weight[1] to 5 mid-burst affects only the next ch1 grant.
